// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage_pkg
//  Brief    : Shared widths, load-type codes and stall-bit indices for the
//             write-back stage and its load alignment helper.
//  Revision : 1.0 - initial release
// ============================================================================
package wb_stage_pkg;

    // Register file geometry
    localparam int          REG_BUS_W      = 32;
    localparam int          REG_ADDR_BUS_W = 5;
    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

    // Load kinds carried down the pipeline; codes 6 and 7 behave as no load
    localparam int         LD_TYPE_W = 3;
    localparam logic [2:0] LD_NONE   = 3'd0;
    localparam logic [2:0] LD_LB     = 3'd1;
    localparam logic [2:0] LD_LBU    = 3'd2;
    localparam logic [2:0] LD_LH     = 3'd3;
    localparam logic [2:0] LD_LHU    = 3'd4;
    localparam logic [2:0] LD_LW     = 3'd5;

    // Positions inside the six-bit pipeline stall vector
    localparam int STALL_W   = 6;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    // Halfword loads need an even offset, word loads a zero offset
    function automatic logic ld_is_misaligned(input logic [2:0] ld_type,
                                              input logic [1:0] addr_lo);
        logic r;
        r = 1'b0;
        case (ld_type)
            LD_LH, LD_LHU: r = addr_lo[0];
            LD_LW:         r = (addr_lo != 2'd0);
            default:       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_ld_align.sv
`default_nettype none
// ============================================================================
//  Module   : wb_ld_align
//  Brief    : Combinational load extraction from a big-endian memory word
//             (byte 0 = bits 31:24) plus misalignment detection.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_ld_align
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W
) (
    input  logic [LD_TYPE_W-1:0] i_ld_type,
    input  logic [DATA_W-1:0]    i_ld_word,
    input  logic [1:0]           i_addr_lo,
    input  logic [DATA_W-1:0]    i_alu_wdata,
    output logic [DATA_W-1:0]    o_wdata,
    output logic                 o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte/halfword and extend it to the register width
    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_ld_word[31:24];
            2'd1:    w_byte = i_ld_word[23:16];
            2'd2:    w_byte = i_ld_word[15:8];
            default: w_byte = i_ld_word[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_ld_word[15:0] : i_ld_word[31:16];

        o_wdata = i_alu_wdata;
        case (i_ld_type)
            LD_LB:   o_wdata = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LD_LBU:  o_wdata = {{(DATA_W-8){1'b0}}, w_byte};
            LD_LH:   o_wdata = {{(DATA_W-16){w_half[15]}}, w_half};
            LD_LHU:  o_wdata = {{(DATA_W-16){1'b0}}, w_half};
            LD_LW:   o_wdata = i_ld_word;
            default: o_wdata = i_alu_wdata;
        endcase

        o_misaligned = ld_is_misaligned(i_ld_type, i_addr_lo);
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Brief    : MEM/WB pipeline register and write-back stage. Registers the
//             MEM results, extracts load data, blocks misaligned loads,
//             drives the GPR and HI/LO write ports and counts retirements.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_BUS_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 mem_valid,
    input  logic                 mem_wreg,
    input  logic [ADDR_W-1:0]    mem_wd,
    input  logic [DATA_W-1:0]    mem_wdata,
    input  logic                 mem_whilo,
    input  logic [DATA_W-1:0]    mem_hi,
    input  logic [DATA_W-1:0]    mem_lo,
    input  logic [LD_TYPE_W-1:0] mem_ld_type,
    input  logic [DATA_W-1:0]    mem_ld_word,
    input  logic [1:0]           mem_addr_lo,
    output logic                 wb_wreg,
    output logic [ADDR_W-1:0]    wb_wd,
    output logic [DATA_W-1:0]    wb_wdata,
    output logic                 wb_whilo,
    output logic [DATA_W-1:0]    wb_hi,
    output logic [DATA_W-1:0]    wb_lo,
    output logic                 wb_align_err,
    output logic [31:0]          wb_retire_cnt
);

    localparam logic [DATA_W-1:0] c_ZERO_DATA = DATA_W'(ZERO_WORD);

    // WB entry
    logic                 valid_q,   valid_d;
    logic                 wreg_q,    wreg_d;
    logic [ADDR_W-1:0]    wd_q,      wd_d;
    logic [DATA_W-1:0]    wdata_q,   wdata_d;
    logic                 whilo_q,   whilo_d;
    logic [DATA_W-1:0]    hi_q,      hi_d;
    logic [DATA_W-1:0]    lo_q,      lo_d;
    logic [LD_TYPE_W-1:0] ld_type_q, ld_type_d;
    logic [DATA_W-1:0]    ld_word_q, ld_word_d;
    logic [1:0]           addr_lo_q, addr_lo_d;
    // Set once the held entry has already reported its misalignment
    logic                 err_done_q, err_done_d;
    logic [31:0]          retire_cnt_q, retire_cnt_d;

    logic                 w_bubble;
    logic                 w_hold;
    logic                 w_misaligned;
    logic [DATA_W-1:0]    w_ld_wdata;
    logic                 w_unused_stall;

    // Stall bits belonging to earlier stages are not relevant here
    assign w_unused_stall = ^stall[STALL_MEM-1:0];

    assign w_bubble = flush | (stall[STALL_MEM] & ~stall[STALL_WB]);
    assign w_hold   = ~flush & stall[STALL_MEM] & stall[STALL_WB];

    wb_ld_align #(
        .DATA_W (DATA_W)
    ) u_ld_align (
        .i_ld_type    (ld_type_q),
        .i_ld_word    (ld_word_q),
        .i_addr_lo    (addr_lo_q),
        .i_alu_wdata  (wdata_q),
        .o_wdata      (w_ld_wdata),
        .o_misaligned (w_misaligned)
    );

    // Next entry: flush/bubble beats hold, hold beats capture
    always_comb begin
        valid_d   = valid_q;
        wreg_d    = wreg_q;
        wd_d      = wd_q;
        wdata_d   = wdata_q;
        whilo_d   = whilo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        ld_type_d = ld_type_q;
        ld_word_d = ld_word_q;
        addr_lo_d = addr_lo_q;

        if (w_bubble) begin
            valid_d   = 1'b0;
            wreg_d    = 1'b0;
            wd_d      = '0;
            wdata_d   = c_ZERO_DATA;
            whilo_d   = 1'b0;
            hi_d      = c_ZERO_DATA;
            lo_d      = c_ZERO_DATA;
            ld_type_d = LD_NONE;
            ld_word_d = c_ZERO_DATA;
            addr_lo_d = 2'd0;
        end else if (!w_hold) begin
            valid_d   = mem_valid;
            wreg_d    = mem_wreg;
            wd_d      = mem_wd;
            wdata_d   = mem_wdata;
            whilo_d   = mem_whilo;
            hi_d      = mem_hi;
            lo_d      = mem_lo;
            ld_type_d = mem_ld_type;
            ld_word_d = mem_ld_word;
            addr_lo_d = mem_addr_lo;
        end
    end

    // Error-pulse bookkeeping and retirement counter
    always_comb begin
        err_done_d   = w_hold & (err_done_q | wb_align_err);
        retire_cnt_d = retire_cnt_q;
        if (valid_q && !stall[STALL_WB]) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    // State registers, cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            wreg_q       <= 1'b0;
            wd_q         <= '0;
            wdata_q      <= c_ZERO_DATA;
            whilo_q      <= 1'b0;
            hi_q         <= c_ZERO_DATA;
            lo_q         <= c_ZERO_DATA;
            ld_type_q    <= LD_NONE;
            ld_word_q    <= c_ZERO_DATA;
            addr_lo_q    <= 2'd0;
            err_done_q   <= 1'b0;
            retire_cnt_q <= 32'd0;
        end else begin
            valid_q      <= valid_d;
            wreg_q       <= wreg_d;
            wd_q         <= wd_d;
            wdata_q      <= wdata_d;
            whilo_q      <= whilo_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            ld_type_q    <= ld_type_d;
            ld_word_q    <= ld_word_d;
            addr_lo_q    <= addr_lo_d;
            err_done_q   <= err_done_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Outputs come only from registered state
    assign wb_wreg       = valid_q & wreg_q & ~w_misaligned;
    assign wb_wd         = wd_q;
    assign wb_wdata      = w_ld_wdata;
    assign wb_whilo      = valid_q & whilo_q;
    assign wb_hi         = hi_q;
    assign wb_lo         = lo_q;
    assign wb_align_err  = valid_q & w_misaligned & ~err_done_q;
    assign wb_retire_cnt = retire_cnt_q;

endmodule
`default_nettype wire
